// File: rtl/ft60x_multichan_fifo_ctrl.sv
// ft60x_multichan_fifo_ctrl: FT600/FT601 245 sync-FIFO bus master with round-robin TX channels and an RX skid FIFO
module ft60x_multichan_fifo_ctrl #(
  parameter int data_width_p = 32,
  parameter int num_chan_p = 4,
  parameter int max_burst_p = 64,
  parameter int rx_fifo_els_p = 4,
  localparam int tag_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int be_width_lp = data_width_p / 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               txe_n_i,
  input  logic                               rxf_n_i,
  output logic                               wr_n_o,
  output logic                               rd_n_o,
  output logic                               oe_n_o,
  output logic                               siwu_n_o,
  output logic [data_width_p-1:0]            data_o,
  output logic [be_width_lp-1:0]             be_o,
  output logic                               data_oe_o,
  input  logic [data_width_p-1:0]            data_i,
  input  logic [be_width_lp-1:0]             be_i,
  input  logic [num_chan_p*data_width_p-1:0] tx_data_i,
  input  logic [num_chan_p-1:0]              tx_v_i,
  output logic [num_chan_p-1:0]              tx_yumi_o,
  output logic [tag_width_lp-1:0]            tx_tag_o,
  output logic [data_width_p-1:0]            rx_data_o,
  output logic [be_width_lp-1:0]             rx_be_o,
  output logic                               rx_v_o,
  input  logic                               rx_ready_i
);
  localparam int cnt_w_lp = $clog2(max_burst_p + 1);
  localparam int addr_w_lp = $clog2(rx_fifo_els_p);
  typedef enum logic [2:0] {IDLE, TX, RX_OE, RX, RX_END} state_e;
  state_e state, state_n;
  logic [tag_width_lp-1:0] tag, tag_n, ptr, ptr_n, pick, nxt;
  logic [cnt_w_lp-1:0] cnt, cnt_n, cnt_inc;
  logic [data_width_p-1:0] data_n;
  logic [data_width_p-1:0] tx_word [num_chan_p];
  logic [data_width_p+be_width_lp-1:0] mem [rx_fifo_els_p];
  logic [addr_w_lp:0] wp, rp, free;
  logic last_rx, last_rx_n, full, full_n;
  logic wr_n_n, rd_n_n, oe_n_n, data_oe_n;
  logic xfer, hold, load, stop, push, pop, tx_pend, rx_pend;
  int free_after;
  assign siwu_n_o = 1'b1;
  assign tx_tag_o = tag;
  assign xfer = !wr_n_o && !txe_n_i;
  assign hold = full && !xfer;
  assign push = !rd_n_o && !oe_n_o && !rxf_n_i;
  assign pop = rx_v_o && rx_ready_i;
  assign free = (addr_w_lp+1)'(rx_fifo_els_p) - (wp - rp);
  assign free_after = int'(free) + int'(pop) - int'(push);
  assign cnt_inc = cnt + cnt_w_lp'(xfer) + cnt_w_lp'(push);
  // A held word only ever belongs to the current tag, so it counts as pending on its own
  assign tx_pend = !txe_n_i && (full || |tx_v_i);
  assign rx_pend = !rxf_n_i && free >= (addr_w_lp+1)'(3);
  assign nxt = (tag == tag_width_lp'(num_chan_p - 1)) ? '0 : tag + 1'b1;
  assign tx_yumi_o = load ? num_chan_p'(1) << tag : '0;
  assign rx_v_o = wp != rp;
  assign {rx_be_o, rx_data_o} = mem[rp[addr_w_lp-1:0]];
  always_comb begin
    pick = ptr;
    for (int i = 0; i < num_chan_p; i++) tx_word[i] = tx_data_i[i*data_width_p +: data_width_p];
    for (int i = num_chan_p - 1; i >= 0; i--) if (tx_v_i[i]) pick = tag_width_lp'(i);
    for (int i = num_chan_p - 1; i >= 0; i--) if (tx_v_i[i] && i >= int'(ptr)) pick = tag_width_lp'(i);
  end
  always_comb begin
    state_n = state;
    tag_n = tag;
    ptr_n = ptr;
    last_rx_n = last_rx;
    full_n = full;
    cnt_n = cnt_inc;
    data_n = data_o;
    wr_n_n = 1'b1;
    rd_n_n = 1'b1;
    oe_n_n = oe_n_o;
    data_oe_n = 1'b0;
    load = 1'b0;
    stop = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_pend && (!rx_pend || last_rx)) begin
          state_n = TX;
          tag_n = full ? tag : pick;
          last_rx_n = 1'b0;
        end else if (rx_pend) begin
          state_n = RX_OE;
          oe_n_n = 1'b0;
          last_rx_n = 1'b1;
        end
      end
      TX: begin
        load = !txe_n_i && !hold && tx_v_i[tag] && cnt_inc < cnt_w_lp'(max_burst_p);
        stop = txe_n_i || cnt_inc == cnt_w_lp'(max_burst_p) || !(hold || load);
        full_n = hold || load;
        data_n = load ? tx_word[tag] : data_o;
        wr_n_n = stop;
        data_oe_n = !stop;
        if (stop) begin
          state_n = IDLE;
          ptr_n = hold ? tag : nxt;
        end
      end
      RX_OE: begin
        state_n = RX;
        rd_n_n = 1'b0;
      end
      // Exit leaves at least two free slots so nothing in flight can overflow
      RX: begin
        stop = rxf_n_i || free_after <= 2 || cnt_inc == cnt_w_lp'(max_burst_p);
        rd_n_n = stop;
        state_n = stop ? RX_END : RX;
      end
      default: begin
        oe_n_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      tag <= '0;
      ptr <= '0;
      last_rx <= 1'b1;
      full <= 1'b0;
      cnt <= '0;
      data_o <= '0;
      be_o <= '0;
      wr_n_o <= 1'b1;
      rd_n_o <= 1'b1;
      oe_n_o <= 1'b1;
      data_oe_o <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      tag <= tag_n;
      ptr <= ptr_n;
      last_rx <= last_rx_n;
      full <= full_n;
      cnt <= cnt_n;
      data_o <= data_n;
      be_o <= '1;
      wr_n_o <= wr_n_n;
      rd_n_o <= rd_n_n;
      oe_n_o <= oe_n_n;
      data_oe_o <= data_oe_n;
      wp <= wp + (addr_w_lp+1)'(push);
      rp <= rp + (addr_w_lp+1)'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wp[addr_w_lp-1:0]] <= {be_i, data_i};
endmodule

// File: tb/tb_ft60x_multichan_fifo_ctrl.sv
// tb_ft60x_multichan_fifo_ctrl: randomized bench with per-channel and host-order scoreboards
module tb_ft60x_multichan_fifo_ctrl;
  logic clk_i = 1'b0;
  logic reset_n_i, txe_n_i, rxf_n_i, rx_ready_i;
  logic wr_n_o, rd_n_o, oe_n_o, siwu_n_o, data_oe_o, rx_v_o;
  logic [31:0] data_o, data_i, rx_data_o;
  logic [3:0] be_o, be_i, rx_be_o, tx_v_i, tx_yumi_o;
  logic [127:0] tx_data_i;
  logic [1:0] tx_tag_o;
  logic [31:0] src [16][128];
  logic [35:0] host_mem [256];
  int src_wr[16], src_rd[16], exp_rd[16];
  int host_wr, host_rd, out_rd, n_yumi, n_xfer, n_err, n_chk;
  int bursts[$], owners[$];
  logic rx_hold, prev_wr, prev_rd, prev_oe, prev2_oe;
  always #5 clk_i = ~clk_i;
  ft60x_multichan_fifo_ctrl #(.data_width_p(32), .num_chan_p(4), .max_burst_p(2), .rx_fifo_els_p(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .txe_n_i(txe_n_i), .rxf_n_i(rxf_n_i),
    .wr_n_o(wr_n_o), .rd_n_o(rd_n_o), .oe_n_o(oe_n_o), .siwu_n_o(siwu_n_o),
    .data_o(data_o), .be_o(be_o), .data_oe_o(data_oe_o), .data_i(data_i), .be_i(be_i),
    .tx_data_i(tx_data_i), .tx_v_i(tx_v_i), .tx_yumi_o(tx_yumi_o), .tx_tag_o(tx_tag_o),
    .rx_data_o(rx_data_o), .rx_be_o(rx_be_o), .rx_v_o(rx_v_o), .rx_ready_i(rx_ready_i)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      tx_v_i[c] = src_rd[c] < src_wr[c];
      tx_data_i[c*32 +: 32] = src[c][src_rd[c]];
    end
    rxf_n_i = rx_hold || host_rd >= host_wr;
    {be_i, data_i} = host_mem[host_rd];
  endtask
  task automatic add_tx(input int c);
    if (src_wr[c] < 127) begin
      src[c][src_wr[c]] = {4'(c), 28'($urandom)};
      src_wr[c]++;
    end
  endtask
  task automatic add_rx(input logic [31:0] d, input logic [3:0] b);
    if (host_wr < 255) begin
      host_mem[host_wr] = {b, d};
      host_wr++;
    end
  endtask
  function automatic bit tx_done();
    for (int c = 0; c < 4; c++) if (exp_rd[c] != src_wr[c]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit rx_done();
    return out_rd == host_wr;
  endfunction
  // Observe at negedge what the coming posedge will do, then advance the models after it
  task automatic cycle();
    logic [3:0] yum;
    logic xf, cap, pop;
    int ch;
    @(negedge clk_i);
    yum = tx_yumi_o;
    xf = !wr_n_o && !txe_n_i;
    cap = !rd_n_o && !oe_n_o && !rxf_n_i;
    pop = rx_v_o && rx_ready_i;
    if (data_oe_o || !oe_n_o) check("bus_excl", data_oe_o && !oe_n_o, 0);
    check("rx_v", rx_v_o, host_rd != out_rd);
    if (yum != 0) check("yumi_onehot", $countones(yum), 1);
    for (int c = 0; c < 4; c++) if (yum[c]) begin
      check("yumi_valid", src_rd[c] < src_wr[c], 1);
      n_yumi++;
    end
    if (xf) begin
      ch = int'(data_o[31:28]);
      check("tx_known", exp_rd[ch] < src_rd[ch], 1);
      if (exp_rd[ch] < src_rd[ch]) begin
        check("tx_word", data_o, src[ch][exp_rd[ch]]);
        exp_rd[ch]++;
      end
      n_xfer++;
    end
    if (!wr_n_o && prev_wr) begin
      bursts.push_back(int'(data_o[31:28]));
      owners.push_back(0);
    end
    if (!oe_n_o && prev_oe) owners.push_back(1);
    if (!rd_n_o && prev_rd) check("oe_lead", {prev2_oe, prev_oe}, 2'b10);
    if (cap) check("rx_room", (host_rd - out_rd - int'(pop)) < 4, 1);
    if (pop) begin
      check("rx_avail", out_rd < host_rd, 1);
      check("rx_word", {rx_be_o, rx_data_o}, host_mem[out_rd]);
    end
    prev2_oe = prev_oe;
    prev_oe = oe_n_o;
    prev_wr = wr_n_o;
    prev_rd = rd_n_o;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < 4; c++) if (yum[c]) src_rd[c]++;
    if (cap) host_rd++;
    if (pop) out_rd++;
    drive();
  endtask
  initial begin
    logic [31:0] held;
    int total;
    for (int c = 0; c < 16; c++) begin
      src_wr[c] = 0; src_rd[c] = 0; exp_rd[c] = 0;
      for (int k = 0; k < 128; k++) src[c][k] = '0;
    end
    for (int k = 0; k < 256; k++) host_mem[k] = '0;
    {host_wr, host_rd, out_rd, n_yumi, n_xfer, n_err, n_chk} = '0;
    {prev_wr, prev_rd, prev_oe, prev2_oe} = 4'hf;
    reset_n_i = 1'b0; txe_n_i = 1'b1; rx_ready_i = 1'b0; rx_hold = 1'b0;
    drive();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_wr_n", wr_n_o, 1);
    check("rst_rd_n", rd_n_o, 1);
    check("rst_oe_n", oe_n_o, 1);
    check("rst_siwu_n", siwu_n_o, 1);
    check("rst_data_oe", data_oe_o, 0);
    check("rst_data", data_o, 0);
    check("rst_be", be_o, 0);
    check("rst_yumi", tx_yumi_o, 0);
    check("rst_tag", tx_tag_o, 0);
    check("rst_rx_v", rx_v_o, 0);
    reset_n_i = 1'b1;
    // Round robin: four channels of two words each
    for (int c = 0; c < 4; c++) begin add_tx(c); add_tx(c); end
    txe_n_i = 1'b0;
    drive();
    for (int i = 0; i < 200 && !tx_done(); i++) cycle();
    check("rr_done", tx_done(), 1);
    check("rr_xfers", n_xfer, 8);
    check("rr_bursts", bursts.size(), 4);
    for (int i = 0; i < 4; i++) if (i < bursts.size()) check("rr_tag", bursts[i], i);
    // Stall mid-burst: held word must survive three not-ready cycles
    for (int k = 0; k < 4; k++) add_tx(2);
    drive();
    for (int i = 0; i < 50 && exp_rd[2] < 3; i++) cycle();
    txe_n_i = 1'b1;
    drive();
    repeat (3) cycle();
    held = data_o;
    check("stall_hold", held, src[2][exp_rd[2]]);
    check("stall_wr_n", wr_n_o, 1);
    txe_n_i = 1'b0;
    drive();
    for (int i = 0; i < 200 && !tx_done(); i++) cycle();
    check("stall_done", tx_done(), 1);
    // RX stream 0xA0..0xA9
    txe_n_i = 1'b1;
    rx_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) add_rx(32'hA0 + 32'(k), 4'hf);
    drive();
    for (int i = 0; i < 200 && !rx_done(); i++) cycle();
    check("rx_done", rx_done(), 1);
    // Backpressure: bus reads stop once free space reaches two
    rx_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) add_rx($urandom, 4'($urandom));
    drive();
    repeat (40) cycle();
    check("bp_rd_n", rd_n_o, 1);
    check("bp_occ", host_rd - out_rd, 2);
    rx_ready_i = 1'b1;
    drive();
    for (int i = 0; i < 300 && !rx_done(); i++) cycle();
    check("bp_done", rx_done(), 1);
    // Contention: both directions pending, ownership must alternate
    owners.delete();
    for (int c = 0; c < 3; c++) repeat (4) add_tx(c);
    for (int k = 0; k < 12; k++) add_rx($urandom, 4'hf);
    txe_n_i = 1'b0;
    drive();
    for (int i = 0; i < 600 && !(tx_done() && rx_done()); i++) cycle();
    check("cont_done", tx_done() && rx_done(), 1);
    check("cont_owners", owners.size() >= 6, 1);
    for (int i = 1; i < 6; i++) if (i < owners.size()) check("alternate", owners[i] != owners[i-1], 1);
    // Random traffic with stalls, host gaps and consumer backpressure
    repeat (300) begin
      if ($urandom_range(1, 0) == 1) add_tx(int'($urandom_range(3, 0)));
      if ($urandom_range(3, 0) == 0) add_rx($urandom, 4'($urandom));
      txe_n_i = $urandom_range(3, 0) == 0;
      rx_hold = $urandom_range(4, 0) == 0;
      rx_ready_i = $urandom_range(2, 0) != 0;
      drive();
      cycle();
    end
    txe_n_i = 1'b0;
    rx_hold = 1'b0;
    rx_ready_i = 1'b1;
    drive();
    for (int i = 0; i < 2000 && !(tx_done() && rx_done()); i++) cycle();
    for (int c = 0; c < 4; c++) check("tx_drain", exp_rd[c], src_wr[c]);
    check("rx_drain", out_rd, host_wr);
    total = 0;
    for (int c = 0; c < 4; c++) total += src_wr[c];
    check("yumi_total", n_yumi, total);
    // Asynchronous reset while a burst is driving the bus
    repeat (4) add_tx(3);
    drive();
    for (int i = 0; i < 50 && wr_n_o; i++) cycle();
    check("rst_mid_tx", wr_n_o, 0);
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_wr_n", wr_n_o, 1);
    check("arst_data_oe", data_oe_o, 0);
    check("arst_rx_v", rx_v_o, 0);
    check("arst_yumi", tx_yumi_o, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
